dmem_arbiter: RTL and testbench

- Shares the single data-memory port between two requesters: the core load/store path (requester 0) and the program/debug loader (requester 1).
- Round-robin arbitration with a consecutive-grant burst limit, so neither requester is starved.
- Sits between the ALU address/rd2 outputs and loader on one side, and the data memory on the other.
- Provides a core stall signal and routes synchronous read data back to the issuing requester.

---
 rtl/riscv_pkg.sv | 23 ++
 rtl/burst_rr_arb.sv | 74 +++++++
 rtl/dmem_arbiter.sv | 109 ++++++++++
 tb/tb_dmem_arbiter.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared types and constants for the data-memory arbiter
//
// Purpose : requester identifiers, default data-memory widths and a helper
//           that sizes the burst counter.
// Ports   : none (package).

package riscv_pkg;

   // Identifies which side of the arbiter owns or issued an access.
   typedef enum logic {
      REQ_CORE   = 1'b0,
      REQ_LOADER = 1'b1
   } req_id_t;

   localparam int DMEM_ADDR_W = 32;
   localparam int DMEM_DATA_W = 32;

   // Bits needed to hold 0..max_burst inclusive.
   function automatic int burst_cnt_w(input int max_burst);
      return $clog2(max_burst + 1);
   endfunction

endpackage

// File: rtl/burst_rr_arb.sv
// rtl/burst_rr_arb.sv - two-way round-robin arbiter with a consecutive-grant limit
//
// Purpose : grants one of two requesters per cycle. A lone requester is always
//           granted. Under contention the current owner keeps the grant until
//           it has been granted MAX_BURST times in a row, then the other side
//           takes over.
// Ports   : clk, reset      - clock and synchronous active-high reset
//           req[1:0]        - request bits, index 0 = core, 1 = loader
//           gnt[1:0]        - one-hot grant (all zero during reset or when idle)

module burst_rr_arb
   import riscv_pkg::*;
#(
   parameter int MAX_BURST = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   output logic [1:0] gnt
);

   localparam int            CW      = burst_cnt_w(MAX_BURST);
   localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   req_id_t       owner;
   req_id_t       pick;
   logic [CW-1:0] burst_cnt;
   logic          any_req;

   always_comb begin
      any_req = req[0] | req[1];

      if (req[0] && req[1]) begin
         // Contention: owner keeps the port until its burst is spent.
         if (burst_cnt < CNT_MAX) begin
            pick = owner;
         end else begin
            pick = (owner == REQ_CORE) ? REQ_LOADER : REQ_CORE;
         end
      end else if (req[1]) begin
         pick = REQ_LOADER;
      end else begin
         pick = REQ_CORE;
      end

      gnt = 2'b00;
      if (any_req && !reset) begin
         if (pick == REQ_LOADER) begin
            gnt[1] = 1'b1;
         end else begin
            gnt[0] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         owner     <= REQ_CORE;
         burst_cnt <= '0;
      end else if (any_req) begin
         if (pick == owner) begin
            // Saturate so a long uncontended run never wraps back below the limit.
            if (burst_cnt != CNT_MAX) begin
               burst_cnt <= burst_cnt + CNT_ONE;
            end
         end else begin
            owner     <= pick;
            burst_cnt <= CNT_ONE;
         end
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - shares the data-memory port between core and loader
//
// Purpose : arbitrates core load/store and loader accesses onto one
//           synchronous data memory, stalls the core while it loses
//           arbitration, and steers read data back to the issuing requester.
// Ports   : clk, reset                         - clock, synchronous active-high reset
//           c_req/c_we/c_addr/c_wdata          - core request
//           c_gnt/c_rvalid/c_rdata, core_stall - core grant, read response, stall
//           l_req/l_we/l_addr/l_wdata          - loader request
//           l_gnt/l_rvalid/l_rdata             - loader grant and read response
//           m_addr/m_wdata/m_we/m_re           - memory command
//           m_rdata                            - memory read data, one cycle after m_re

module dmem_arbiter
   import riscv_pkg::*;
#(
   parameter int ADDR_W    = DMEM_ADDR_W,
   parameter int DATA_W    = DMEM_DATA_W,
   parameter int MAX_BURST = 8
) (
   input  logic              clk,
   input  logic              reset,

   input  logic              c_req,
   input  logic              c_we,
   input  logic [ADDR_W-1:0] c_addr,
   input  logic [DATA_W-1:0] c_wdata,
   output logic              c_gnt,
   output logic              c_rvalid,
   output logic [DATA_W-1:0] c_rdata,
   output logic              core_stall,

   input  logic              l_req,
   input  logic              l_we,
   input  logic [ADDR_W-1:0] l_addr,
   input  logic [DATA_W-1:0] l_wdata,
   output logic              l_gnt,
   output logic              l_rvalid,
   output logic [DATA_W-1:0] l_rdata,

   output logic [ADDR_W-1:0] m_addr,
   output logic [DATA_W-1:0] m_wdata,
   output logic              m_we,
   output logic              m_re,
   input  logic [DATA_W-1:0] m_rdata
);

   logic [1:0] gnt;
   logic       any_gnt;
   logic       sel_we;
   req_id_t    gnt_id;
   logic       rsp_pending;
   req_id_t    rsp_id;

   burst_rr_arb #(
      .MAX_BURST (MAX_BURST)
   ) u_arb (
      .clk   (clk),
      .reset (reset),
      .req   ({l_req, c_req}),
      .gnt   (gnt)
   );

   assign c_gnt   = gnt[0];
   assign l_gnt   = gnt[1];
   assign any_gnt = gnt[0] | gnt[1];
   assign gnt_id  = gnt[1] ? REQ_LOADER : REQ_CORE;

   // Command mux: the memory bus is driven to zero whenever nobody is granted.
   always_comb begin
      m_addr  = '0;
      m_wdata = '0;
      sel_we  = 1'b0;
      if (gnt[0]) begin
         m_addr  = c_addr;
         m_wdata = c_wdata;
         sel_we  = c_we;
      end else if (gnt[1]) begin
         m_addr  = l_addr;
         m_wdata = l_wdata;
         sel_we  = l_we;
      end
   end

   assign m_we = any_gnt & sel_we;
   assign m_re = any_gnt & ~sel_we;

   // The arbiter already drops grants in reset; gating here keeps the stall
   // quiet too even though c_req may be high.
   assign core_stall = c_req & ~c_gnt & ~reset;

   // Remember which side issued last cycle's read so its data goes back there.
   always_ff @(posedge clk) begin
      if (reset) begin
         rsp_pending <= 1'b0;
         rsp_id      <= REQ_CORE;
      end else begin
         rsp_pending <= m_re;
         rsp_id      <= gnt_id;
      end
   end

   // A read issued just before reset lands in the reset cycle; suppress it.
   assign c_rvalid = rsp_pending & (rsp_id == REQ_CORE)   & ~reset;
   assign l_rvalid = rsp_pending & (rsp_id == REQ_LOADER) & ~reset;
   assign c_rdata  = m_rdata;
   assign l_rdata  = m_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

   logic        clk;
   logic        reset;

   logic        c_req, c_we;
   logic [31:0] c_addr, c_wdata;
   logic        c_gnt, c_rvalid, core_stall;
   logic [31:0] c_rdata;
   logic        l_req, l_we;
   logic [31:0] l_addr, l_wdata;
   logic        l_gnt, l_rvalid;
   logic [31:0] l_rdata;
   logic [31:0] m_addr, m_wdata, m_rdata;
   logic        m_we, m_re;

   logic        b_c_req, b_c_we, b_l_req, b_l_we;
   logic [31:0] b_c_addr, b_c_wdata, b_l_addr, b_l_wdata;
   logic        b_c_gnt, b_c_rvalid, b_core_stall, b_l_gnt, b_l_rvalid;
   logic [31:0] b_c_rdata, b_l_rdata, b_m_addr, b_m_wdata, b_m_rdata;
   logic        b_m_we, b_m_re;

   int pass_cnt;
   int total_cnt;

   dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_BURST(8)) dut (
      .clk(clk), .reset(reset),
      .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
      .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata), .core_stall(core_stall),
      .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
      .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
      .m_addr(m_addr), .m_wdata(m_wdata), .m_we(m_we), .m_re(m_re), .m_rdata(m_rdata)
   );

   dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_BURST(1)) dut_b1 (
      .clk(clk), .reset(reset),
      .c_req(b_c_req), .c_we(b_c_we), .c_addr(b_c_addr), .c_wdata(b_c_wdata),
      .c_gnt(b_c_gnt), .c_rvalid(b_c_rvalid), .c_rdata(b_c_rdata), .core_stall(b_core_stall),
      .l_req(b_l_req), .l_we(b_l_we), .l_addr(b_l_addr), .l_wdata(b_l_wdata),
      .l_gnt(b_l_gnt), .l_rvalid(b_l_rvalid), .l_rdata(b_l_rdata),
      .m_addr(b_m_addr), .m_wdata(b_m_wdata), .m_we(b_m_we), .m_re(b_m_re), .m_rdata(b_m_rdata)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Memory model: 0x40 holds 0xDEADBEEF, every other word holds ~address.
   always @(posedge clk) begin
      if (m_re) m_rdata <= (m_addr == 32'h40) ? 32'hDEADBEEF : ~m_addr;
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      total_cnt++;
      if (got !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
      else pass_cnt++;
   endtask

   task automatic idle_inputs;
      c_req = 0; c_we = 0; c_addr = 0; c_wdata = 0;
      l_req = 0; l_we = 0; l_addr = 0; l_wdata = 0;
      b_c_req = 0; b_c_we = 0; b_c_addr = 0; b_c_wdata = 0;
      b_l_req = 0; b_l_we = 0; b_l_addr = 0; b_l_wdata = 0;
   endtask

   task automatic do_reset;
      idle_inputs();
      reset = 1;
      tick();
      tick();
      reset = 0;
   endtask

   task automatic test_reset;
      reset = 1;
      c_req = 1; c_we = 0; c_addr = 32'h10;
      l_req = 1; l_we = 0; l_addr = 32'h20;
      for (int i = 0; i < 2; i++) begin
         #2;
         chk("rst_c_gnt", {31'b0, c_gnt}, 0);
         chk("rst_l_gnt", {31'b0, l_gnt}, 0);
         chk("rst_m_we", {31'b0, m_we}, 0);
         chk("rst_m_re", {31'b0, m_re}, 0);
         chk("rst_stall", {31'b0, core_stall}, 0);
         chk("rst_rvalid", {30'b0, c_rvalid, l_rvalid}, 0);
         chk("rst_m_addr", m_addr, 0);
         tick();
      end
      reset = 0;
      #2;
      chk("post_rst_c_gnt", {31'b0, c_gnt}, 1);
      chk("post_rst_l_gnt", {31'b0, l_gnt}, 0);
      chk("post_rst_stall", {31'b0, core_stall}, 0);
      tick();
   endtask

   task automatic test_contention;
      logic exp_c, prev_c;
      do_reset();
      c_req = 1; c_we = 0; c_addr = 32'h40;
      l_req = 1; l_we = 0; l_addr = 32'h200;
      for (int i = 0; i < 24; i++) begin
         #2;
         exp_c = (i < 8) || (i >= 16);
         chk($sformatf("cont_c_gnt[%0d]", i), {31'b0, c_gnt}, {31'b0, exp_c});
         chk($sformatf("cont_l_gnt[%0d]", i), {31'b0, l_gnt}, {31'b0, !exp_c});
         chk($sformatf("cont_stall[%0d]", i), {31'b0, core_stall}, {31'b0, !exp_c});
         chk($sformatf("cont_m_addr[%0d]", i), m_addr, exp_c ? 32'h40 : 32'h200);
         if (i > 0) begin
            prev_c = ((i - 1) < 8) || ((i - 1) >= 16);
            chk($sformatf("cont_c_rvalid[%0d]", i), {31'b0, c_rvalid}, {31'b0, prev_c});
            chk($sformatf("cont_l_rvalid[%0d]", i), {31'b0, l_rvalid}, {31'b0, !prev_c});
            if (prev_c) chk($sformatf("cont_c_rdata[%0d]", i), c_rdata, 32'hDEADBEEF);
            else        chk($sformatf("cont_l_rdata[%0d]", i), l_rdata, 32'hFFFFFDFF);
         end
         tick();
      end
   endtask

   task automatic test_loader_write;
      do_reset();
      l_req = 1; l_we = 1;
      for (int i = 0; i < 20; i++) begin
         l_addr = i * 4;
         l_wdata = i * 4;
         #2;
         chk($sformatf("lw_l_gnt[%0d]", i), {31'b0, l_gnt}, 1);
         chk($sformatf("lw_m_we[%0d]", i), {31'b0, m_we}, 1);
         chk($sformatf("lw_m_re[%0d]", i), {31'b0, m_re}, 0);
         chk($sformatf("lw_m_addr[%0d]", i), m_addr, i * 4);
         chk($sformatf("lw_m_wdata[%0d]", i), m_wdata, i * 4);
         chk($sformatf("lw_stall[%0d]", i), {31'b0, core_stall}, 0);
         chk($sformatf("lw_rvalid[%0d]", i), {30'b0, c_rvalid, l_rvalid}, 0);
         tick();
      end
      l_req = 0; l_we = 0;
   endtask

   task automatic test_core_read;
      do_reset();
      c_req = 1; c_we = 0; c_addr = 32'h40;
      #2;
      chk("cr_c_gnt", {31'b0, c_gnt}, 1);
      chk("cr_m_re", {31'b0, m_re}, 1);
      chk("cr_m_addr", m_addr, 32'h40);
      tick();
      c_req = 0;
      #2;
      chk("cr_c_rvalid", {31'b0, c_rvalid}, 1);
      chk("cr_c_rdata", c_rdata, 32'hDEADBEEF);
      chk("cr_l_rvalid", {31'b0, l_rvalid}, 0);
      chk("cr_m_re_idle", {31'b0, m_re}, 0);
      tick();
      #2;
      chk("cr_c_rvalid_after", {31'b0, c_rvalid}, 0);
      tick();
   endtask

   task automatic test_reset_mid_read;
      do_reset();
      l_req = 1; l_we = 0; l_addr = 32'h80;
      #2;
      chk("rm_l_gnt", {31'b0, l_gnt}, 1);
      chk("rm_m_re", {31'b0, m_re}, 1);
      tick();
      l_req = 0;
      reset = 1;
      #2;
      chk("rm_l_rvalid_n1", {31'b0, l_rvalid}, 0);
      chk("rm_c_rvalid_n1", {31'b0, c_rvalid}, 0);
      tick();
      reset = 0;
      c_req = 1; c_we = 0; c_addr = 32'h44;
      l_req = 1; l_we = 0; l_addr = 32'h84;
      #2;
      chk("rm_l_rvalid_n2", {31'b0, l_rvalid}, 0);
      chk("rm_c_gnt_after", {31'b0, c_gnt}, 1);
      chk("rm_l_gnt_after", {31'b0, l_gnt}, 0);
      tick();
      idle_inputs();
   endtask

   task automatic test_alternation;
      do_reset();
      c_req = 1; c_addr = 32'h100;
      #2;
      chk("alt_core0", {30'b0, l_gnt, c_gnt}, 2'b01);
      tick();
      c_req = 0; l_req = 1; l_addr = 32'h104;
      #2;
      chk("alt_loader", {30'b0, l_gnt, c_gnt}, 2'b10);
      chk("alt_loader_stall", {31'b0, core_stall}, 0);
      tick();
      l_req = 0; c_req = 1;
      #2;
      chk("alt_core1", {30'b0, l_gnt, c_gnt}, 2'b01);
      tick();
      // Core now owns with a count of 1: seven more contended grants, then loader.
      l_req = 1;
      for (int i = 0; i < 9; i++) begin
         #2;
         chk($sformatf("alt_both[%0d]", i), {30'b0, l_gnt, c_gnt}, (i < 7) ? 2'b01 : 2'b10);
         tick();
      end
      idle_inputs();
   endtask

   task automatic test_burst1;
      do_reset();
      b_c_req = 1; b_c_addr = 32'h8;
      b_l_req = 1; b_l_addr = 32'hC;
      for (int i = 0; i < 6; i++) begin
         #2;
         chk($sformatf("b1_gnt[%0d]", i), {30'b0, b_l_gnt, b_c_gnt}, (i % 2 == 0) ? 2'b01 : 2'b10);
         chk($sformatf("b1_stall[%0d]", i), {31'b0, b_core_stall}, (i % 2 == 0) ? 0 : 1);
         tick();
      end
      idle_inputs();
   endtask

   initial begin
      pass_cnt = 0;
      total_cnt = 0;
      b_m_rdata = 32'h0;
      idle_inputs();
      reset = 1;
      tick();
      test_reset();
      test_contention();
      test_loader_write();
      test_core_read();
      test_reset_mid_read();
      test_alternation();
      test_burst1();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
